// File: rtl/branch_stack_pkg.sv
// Shared definitions for the CGRA branch stack and everything that drives it:
// op encodings and default sizing of the depth counter.
package branch_stack_pkg;

  typedef enum logic [1:0] {
    OP_PEEK    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } op_e;

  localparam int unsigned DEPTH_W_DEF     = 10;
  localparam int unsigned STACK_DEPTH_DEF = 1023;

  // REPLACE drives both push and pop into the stack.
  function automatic logic op_pushes(op_e op);
    return (op == OP_PUSH) || (op == OP_REPLACE);
  endfunction

  function automatic logic op_pops(op_e op);
    return (op == OP_POP) || (op == OP_REPLACE);
  endfunction

endpackage

// File: rtl/branch_stack_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer, wrapping,
// and moves the pointer one past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    gnt      = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    idx      = '0;
    if (advance) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = PtrW'((int'(rr_ptr_q) + k) % int'(NREQ));
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          rr_ptr_d = PtrW'((int'(idx) + 1) % int'(NREQ));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/branch_stack_arbiter.sv
// Shares one single-bit branch stack among NREQ requesters: one op per cycle, drives the
// stack combinationally and returns post-op top, error flag and depth one cycle later.
module branch_stack_arbiter
  import branch_stack_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned DEPTH_W     = DEPTH_W_DEF,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   op,
  input  logic [NREQ-1:0]     din,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rsp_valid,
  output logic                rsp_data,
  output logic                rsp_err,
  output logic [DEPTH_W-1:0]  depth,
  output logic                stk_en,
  output logic                stk_push,
  output logic                stk_pop,
  output logic                stk_din,
  input  logic                stk_dout
);

  logic [NREQ-1:0]    rsp_valid_q;
  logic               rsp_err_q, rsp_err_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  op_e                op_sel;
  logic               din_sel;

  // Reset blocks grants so the shared stack never sees an op while it is being cleared.
  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .advance(en & ~rst),
    .gnt    (gnt)
  );

  always_comb begin
    op_sel  = OP_PEEK;
    din_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        op_sel  = op_e'(op[2*i +: 2]);
        din_sel = din[i];
      end
    end
  end

  assign stk_en   = |gnt;
  assign stk_push = stk_en & op_pushes(op_sel);
  assign stk_pop  = stk_en & op_pops(op_sel);
  assign stk_din  = stk_en & din_sel;

  // Mirror the stack's saturating pointer so depth always matches its occupancy.
  always_comb begin
    depth_d   = depth_q;
    rsp_err_d = 1'b0;
    if (stk_en) begin
      case (op_sel)
        OP_PUSH: begin
          if (depth_q == DEPTH_W'(STACK_DEPTH)) rsp_err_d = 1'b1;
          else                                  depth_d   = depth_q + DEPTH_W'(1);
        end
        OP_POP: begin
          if (depth_q == '0) rsp_err_d = 1'b1;
          else               depth_d   = depth_q - DEPTH_W'(1);
        end
        OP_REPLACE: begin
          if (depth_q == '0) depth_d = DEPTH_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      depth_q     <= '0;
    end else begin
      rsp_valid_q <= gnt;
      rsp_err_q   <= rsp_err_d;
      depth_q     <= depth_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = stk_dout;
  assign depth     = depth_q;

endmodule

// File: tb/tb_branch_stack_arbiter.sv
// Bench for branch_stack_arbiter with a behavioural single-bit stack attached; directed ops
// queue hand-computed responses that a monitor checks as rsp_valid appears.
module tb_branch_stack_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 10;
  localparam int SDEP  = 1023;

  logic            clk = 1'b0;
  logic            rst, en;
  logic [NREQ-1:0] req, din, gnt, rsp_valid;
  logic [2*NREQ-1:0] op;
  logic            rsp_data, rsp_err;
  logic [DW-1:0]   depth;
  logic            stk_en, stk_push, stk_pop, stk_din, stk_dout;

  always #5 clk = ~clk;

  branch_stack_arbiter #(
    .NREQ       (NREQ),
    .DEPTH_W    (DW),
    .STACK_DEPTH(SDEP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .op       (op),
    .din      (din),
    .gnt      (gnt),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .depth    (depth),
    .stk_en   (stk_en),
    .stk_push (stk_push),
    .stk_pop  (stk_pop),
    .stk_din  (stk_din),
    .stk_dout (stk_dout)
  );

  // Behavioural branch stack sharing rst: saturating pointer, full push overwrites top.
  bit stk_mem [SDEP+1];
  int stk_ptr;

  always @(posedge clk) begin
    if (rst) begin
      stk_ptr <= 0;
    end else if (stk_en) begin
      if (stk_push && stk_pop) begin
        if (stk_ptr == 0) begin
          stk_mem[0] <= stk_din;
          stk_ptr    <= 1;
        end else begin
          stk_mem[stk_ptr-1] <= stk_din;
        end
      end else if (stk_push) begin
        if (stk_ptr < SDEP) begin
          stk_mem[stk_ptr] <= stk_din;
          stk_ptr          <= stk_ptr + 1;
        end else begin
          stk_mem[stk_ptr-1] <= stk_din;
        end
      end else if (stk_pop) begin
        if (stk_ptr > 0) stk_ptr <= stk_ptr - 1;
      end
    end
  end

  assign stk_dout = (stk_ptr == 0) ? 1'b0 : stk_mem[(stk_ptr == 0) ? 0 : stk_ptr-1];

  typedef struct packed {
    logic [NREQ-1:0] lane;
    logic            data;
    logic            err;
    logic [DW-1:0]   dep;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_rsp(input logic [NREQ-1:0] lane, input logic d, input logic e,
                            input int dp);
    exp_t x;
    x.lane = lane;
    x.data = d;
    x.err  = e;
    x.dep  = DW'(dp);
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (!rst && |rsp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b expected none", rsp_valid);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_lane", 32'(rsp_valid), 32'(mon_e.lane));
        check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        check("depth", 32'(depth), 32'(mon_e.dep));
      end
    end
  end

  // Single-lane op; called in the phase just after a posedge, returns in the same phase.
  task automatic issue(input int lane, input logic [1:0] o, input logic d,
                       input logic ed, input logic ee, input int edp);
    bit got = 0;
    req[lane]         = 1'b1;
    op[2*lane +: 2]   = o;
    din[lane]         = d;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (gnt[lane]) begin
        got = 1;
        check("stk_push", 32'(stk_push), 32'(o == 2'd1 || o == 2'd3));
        check("stk_pop", 32'(stk_pop), 32'(o == 2'd2 || o == 2'd3));
        expect_rsp(NREQ'(1 << lane), ed, ee, edp);
      end else begin
        @(posedge clk) #1;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL grant_timeout: got no gnt expected gnt on lane %0d", lane);
    end
    @(posedge clk) #1;
    req[lane] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    req = '1;
    op  = '0;
    din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_stk_en", 32'(stk_en), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_depth", 32'(depth), 32'h0);
    @(posedge clk) #1;
    req = '0;
    rst = 1'b0;

    // Push 1,0,1 then pop three times on lane 0.
    issue(0, 2'd1, 1'b1, 1'b1, 1'b0, 1);
    issue(0, 2'd1, 1'b0, 1'b0, 1'b0, 2);
    issue(0, 2'd1, 1'b1, 1'b1, 1'b0, 3);
    issue(0, 2'd2, 1'b0, 1'b0, 1'b0, 2);
    issue(0, 2'd2, 1'b0, 1'b1, 1'b0, 1);
    issue(0, 2'd2, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;

    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;

    // All lanes PEEK continuously: grants rotate 0,1,2,3,0,...
    req = 4'b1111;
    op  = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
      expect_rsp(NREQ'(1 << (k % 4)), 1'b0, 1'b0, 0);
      @(posedge clk) #1;
    end
    req = '0;

    // Stall: no grants while en=0, then lane 0 followed by lane 2.
    en  = 1'b0;
    req = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_gnt", 32'(gnt), 32'h0);
      check("stall_stk_en", 32'(stk_en), 32'h0);
      @(posedge clk) #1;
    end
    en = 1'b1;
    @(negedge clk);
    check("unstall_gnt0", 32'(gnt), 32'h1);
    expect_rsp(4'b0001, 1'b0, 1'b0, 0);
    @(posedge clk) #1;
    req = 4'b0100;
    @(negedge clk);
    check("unstall_gnt2", 32'(gnt), 32'h4);
    expect_rsp(4'b0100, 1'b0, 1'b0, 0);
    @(posedge clk) #1;
    req = '0;

    // Underflow, then REPLACE on empty behaves as a push.
    issue(1, 2'd2, 1'b0, 1'b0, 1'b1, 0);
    issue(1, 2'd3, 1'b1, 1'b1, 1'b0, 1);
    issue(1, 2'd2, 1'b0, 1'b0, 1'b0, 0);

    // Fill to capacity, overflow overwrites the top, then pop exposes the old entry.
    for (int i = 0; i < SDEP; i++) issue(2, 2'd1, 1'b1, 1'b1, 1'b0, i + 1);
    issue(2, 2'd1, 1'b0, 1'b0, 1'b1, SDEP);
    issue(2, 2'd2, 1'b0, 1'b1, 1'b0, SDEP - 1);
    repeat (2) @(posedge clk);
    #1;

    // Reset lands while a response is in flight; it must not survive.
    req[3]  = 1'b1;
    op[7:6] = 2'd2;
    @(negedge clk);
    check("pre_rst_gnt", 32'(gnt), 32'h8);
    @(posedge clk) #1;
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_depth", 32'(depth), 32'h0);
    @(posedge clk) #1;
    rst = 1'b0;
    req = 4'b1010;
    op  = '0;
    @(negedge clk);
    check("post_rst_gnt", 32'(gnt), 32'h2);
    expect_rsp(4'b0010, 1'b0, 1'b0, 0);
    @(posedge clk) #1;
    req = '0;

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
